zx_cart_bus_master: RTL and testbench

- Z80-style bus initiator that drives the cartridge's CPU-side interface: memory reads, port-0x7F page-up accesses and cartridge reset.
- Used on the FPGA test/loader fixture in place of the Spectrum CPU to dump cartridge banks and exercise bank stepping and self-lock.
- Keeps a shadow copy of the cartridge bank counter and self-lock flag, so the host knows which 8 KB bank is mapped without reading back.

---
 rtl/zx_cart_bus_master_if.sv | 35 +++
 rtl/zx_cart_bus_master.sv | 261 ++++++++++++++++++++++++++
 tb/tb_zx_cart_bus_master.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/zx_cart_bus_master_if.sv
// Bus bundle between the Z80-style initiator and the cartridge side of
// the loader fixture: host command/response handshake, cartridge strobes,
// address/data and the mirrored bank state.
interface zx_cart_bus_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_addr;
    logic [5:0]  cmd_bank;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_err;
    logic        cart_reset_n;
    logic        mreq_n;
    logic        iorq_n;
    logic        rd_n;
    logic [15:0] A;
    logic [7:0]  d_in;
    logic [5:0]  shadow_bank;
    logic        shadow_lock;

    // The bus master drives strobes, address and responses.
    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_bank, d_in,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, cart_reset_n,
        output mreq_n, iorq_n, rd_n, A, shadow_bank, shadow_lock
    );

    // The host/cartridge side sees the mirror image.
    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_bank, d_in,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, cart_reset_n,
        input  mreq_n, iorq_n, rd_n, A, shadow_bank, shadow_lock
    );
endinterface

// File: rtl/zx_cart_bus_master.sv
// Z80-style bus initiator for the cartridge loader fixture. It runs memory
// reads, port-0x7F page-up cycles and cartridge resets, and keeps a shadow
// of the cartridge bank counter and self-lock flag so the host always knows
// which 8 KB bank is mapped.
module zx_cart_bus_master #(
    parameter int T_CLKS        = 2,
    parameter int SELF_LOCK_VAL = 15,
    parameter int RESET_CLKS    = 4
) (
    input logic                  clk,
    input logic                  reset_n,
    zx_cart_bus_master_if.master bus
);

    localparam int TCW = (T_CLKS > 1) ? $clog2(T_CLKS) : 1;
    localparam int RCW = (RESET_CLKS > 1) ? $clog2(RESET_CLKS) : 1;
    localparam logic [TCW-1:0] T_LAST   = TCW'(T_CLKS - 1);
    localparam logic [RCW-1:0] R_LAST   = RCW'(RESET_CLKS - 1);
    localparam logic [5:0]     LOCK_VAL = 6'(SELF_LOCK_VAL);
    localparam logic [15:0]    PAGE_PORT = 16'h007F;

    localparam logic [1:0] OP_MEM_RD     = 2'd0;
    localparam logic [1:0] OP_PAGE_UP    = 2'd1;
    localparam logic [1:0] OP_SELECT     = 2'd2;
    localparam logic [1:0] OP_CART_RESET = 2'd3;

    // S_GAP is the idle T-state inserted after each page-up of a bank select.
    typedef enum logic [2:0] {
        S_IDLE,
        S_MEM,
        S_PAGE,
        S_GAP,
        S_RST,
        S_RESP
    } state_e;

    state_e         state_q;
    logic [TCW-1:0] tcnt_q;
    logic [1:0]     tidx_q;
    logic [RCW-1:0] rcnt_q;
    logic [5:0]     remain_q;
    logic [5:0]     target_q;
    logic           sel_q;
    logic           err_q;

    logic           cmd_ready_q;
    logic           rsp_valid_q;
    logic [7:0]     rsp_data_q;
    logic           rsp_err_q;
    logic           cart_reset_n_q;
    logic           mreq_n_q;
    logic           iorq_n_q;
    logic           rd_n_q;
    logic [15:0]    addr_q;
    logic [5:0]     bank_q;
    logic           lock_q;

    logic [5:0]     bank_inc_d;
    logic           lock_inc_d;
    logic           t_last;

    assign t_last = (tcnt_q == T_LAST);

    // Shadow state after one cartridge page-up; a locked cartridge ignores it.
    always_comb begin
        bank_inc_d = bank_q;
        lock_inc_d = lock_q;
        if (!lock_q) begin
            bank_inc_d = bank_q + 6'd1;
            lock_inc_d = (bank_q == LOCK_VAL);
        end
    end

    // Command sequencer with registered bus strobes, responses and shadows.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            tcnt_q         <= '0;
            tidx_q         <= 2'd0;
            rcnt_q         <= '0;
            remain_q       <= 6'd0;
            target_q       <= 6'd0;
            sel_q          <= 1'b0;
            err_q          <= 1'b0;
            cmd_ready_q    <= 1'b1;
            rsp_valid_q    <= 1'b0;
            rsp_data_q     <= 8'h00;
            rsp_err_q      <= 1'b0;
            cart_reset_n_q <= 1'b0;
            mreq_n_q       <= 1'b1;
            iorq_n_q       <= 1'b1;
            rd_n_q         <= 1'b1;
            addr_q         <= 16'h0000;
            bank_q         <= 6'd0;
            lock_q         <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cart_reset_n_q <= 1'b1;
                    mreq_n_q       <= 1'b1;
                    iorq_n_q       <= 1'b1;
                    rd_n_q         <= 1'b1;
                    cmd_ready_q    <= 1'b1;
                    tcnt_q         <= '0;
                    tidx_q         <= 2'd0;
                    rcnt_q         <= '0;
                    if (bus.cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        sel_q       <= 1'b0;
                        err_q       <= lock_q;
                        case (bus.cmd_op)
                            OP_MEM_RD: begin
                                addr_q  <= bus.cmd_addr;
                                state_q <= S_MEM;
                            end
                            OP_PAGE_UP: begin
                                addr_q  <= PAGE_PORT;
                                state_q <= S_PAGE;
                            end
                            OP_SELECT: begin
                                if (bus.cmd_bank > LOCK_VAL) begin
                                    rsp_valid_q <= 1'b1;
                                    rsp_err_q   <= 1'b1;
                                    rsp_data_q  <= {2'b00, bank_q};
                                    state_q     <= S_RESP;
                                end else begin
                                    sel_q          <= 1'b1;
                                    remain_q       <= bus.cmd_bank;
                                    target_q       <= bus.cmd_bank;
                                    cart_reset_n_q <= 1'b0;
                                    state_q        <= S_RST;
                                end
                            end
                            OP_CART_RESET: begin
                                cart_reset_n_q <= 1'b0;
                                state_q        <= S_RST;
                            end
                            default: state_q <= S_IDLE;
                        endcase
                    end
                end

                S_MEM: begin
                    if (t_last) begin
                        tcnt_q <= '0;
                        if (tidx_q == 2'd2) begin
                            mreq_n_q    <= 1'b1;
                            rd_n_q      <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= bus.d_in;
                            rsp_err_q   <= lock_q;
                            state_q     <= S_RESP;
                        end else begin
                            tidx_q   <= tidx_q + 2'd1;
                            mreq_n_q <= 1'b0;
                            rd_n_q   <= 1'b0;
                        end
                    end else begin
                        tcnt_q <= tcnt_q + TCW'(1);
                    end
                end

                S_PAGE: begin
                    if (t_last) begin
                        tcnt_q <= '0;
                        if (tidx_q == 2'd3) begin
                            iorq_n_q <= 1'b1;
                            rd_n_q   <= 1'b1;
                            if (sel_q) begin
                                remain_q <= remain_q - 6'd1;
                                state_q  <= S_GAP;
                            end else begin
                                rsp_valid_q <= 1'b1;
                                rsp_data_q  <= {2'b00, bank_q};
                                rsp_err_q   <= err_q;
                                state_q     <= S_RESP;
                            end
                        end else begin
                            tidx_q <= tidx_q + 2'd1;
                            if (tidx_q == 2'd0) begin
                                iorq_n_q <= 1'b0;
                                rd_n_q   <= 1'b0;
                                bank_q   <= bank_inc_d;
                                lock_q   <= lock_inc_d;
                            end
                        end
                    end else begin
                        tcnt_q <= tcnt_q + TCW'(1);
                    end
                end

                S_GAP: begin
                    if (t_last) begin
                        tcnt_q <= '0;
                        tidx_q <= 2'd0;
                        if (remain_q == 6'd0) begin
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= {2'b00, target_q};
                            rsp_err_q   <= 1'b0;
                            state_q     <= S_RESP;
                        end else begin
                            state_q <= S_PAGE;
                        end
                    end else begin
                        tcnt_q <= tcnt_q + TCW'(1);
                    end
                end

                S_RST: begin
                    if (rcnt_q == R_LAST) begin
                        cart_reset_n_q <= 1'b1;
                        bank_q         <= 6'd0;
                        lock_q         <= 1'b0;
                        tcnt_q         <= '0;
                        tidx_q         <= 2'd0;
                        if (sel_q && (remain_q != 6'd0)) begin
                            addr_q  <= PAGE_PORT;
                            state_q <= S_PAGE;
                        end else begin
                            // Either a plain reset or a select of bank 0: bank is now 0.
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= 8'h00;
                            rsp_err_q   <= 1'b0;
                            state_q     <= S_RESP;
                        end
                    end else begin
                        rcnt_q <= rcnt_q + RCW'(1);
                    end
                end

                S_RESP: begin
                    cmd_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end

                default: begin
                    state_q        <= S_IDLE;
                    cmd_ready_q    <= 1'b1;
                    cart_reset_n_q <= 1'b1;
                    mreq_n_q       <= 1'b1;
                    iorq_n_q       <= 1'b1;
                    rd_n_q         <= 1'b1;
                end
            endcase
        end
    end

    assign bus.cmd_ready    = cmd_ready_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.rsp_err      = rsp_err_q;
    assign bus.cart_reset_n = cart_reset_n_q;
    assign bus.mreq_n       = mreq_n_q;
    assign bus.iorq_n       = iorq_n_q;
    assign bus.rd_n         = rd_n_q;
    assign bus.A            = addr_q;
    assign bus.shadow_bank  = bank_q;
    assign bus.shadow_lock  = lock_q;

endmodule

// File: tb/tb_zx_cart_bus_master.sv
// Self-checking bench for zx_cart_bus_master: a table of commands with
// hand-computed responses, strobe counts and shadow state, plus a
// hand-written reset-during-read sequence.
module tb_zx_cart_bus_master;

    localparam int T_CLKS        = 2;
    localparam int SELF_LOCK_VAL = 15;
    localparam int RESET_CLKS    = 4;

    localparam logic [1:0] OP_MEM  = 2'd0;
    localparam logic [1:0] OP_PAGE = 2'd1;
    localparam logic [1:0] OP_SEL  = 2'd2;
    localparam logic [1:0] OP_RST  = 2'd3;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    zx_cart_bus_master_if busIf();

    zx_cart_bus_master #(
        .T_CLKS        (T_CLKS),
        .SELF_LOCK_VAL (SELF_LOCK_VAL),
        .RESET_CLKS    (RESET_CLKS)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (busIf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] addr;
        logic [5:0]  bank;
        logic [7:0]  dIn;
        int          hold;
        int          expLatency;
        int          expMreqLow;
        int          expIorqLow;
        int          expIorqFalls;
        int          expCartLow;
        logic [15:0] expA;
        logic [7:0]  expData;
        logic        expErr;
        logic [5:0]  expBank;
        logic        expLock;
    } vecT;

    typedef struct {
        int          latency;
        int          mreqLow;
        int          iorqLow;
        int          rdLow;
        int          iorqFalls;
        int          cartLow;
        int          aBad;
        logic        readyDuring;
        logic        readyAfter;
        logic        rspAfter;
        logic [7:0]  data;
        logic        err;
        logic [5:0]  bank;
        logic        lock;
    } measT;

    vecT vecs[$];
    int  checks   = 0;
    int  failures = 0;
    int  invViol  = 0;

    logic [15:0] prevA;
    logic        prevStrobesHigh;

    // Watch bus invariants every cycle: no mreq/iorq overlap, A stable while strobed.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (!busIf.mreq_n && !busIf.iorq_n) invViol++;
            if ((busIf.A !== prevA) &&
                !(prevStrobesHigh && busIf.mreq_n && busIf.iorq_n && busIf.rd_n)) invViol++;
        end
        prevA           = busIf.A;
        prevStrobesHigh = busIf.mreq_n && busIf.iorq_n && busIf.rd_n;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void addVec(input logic [1:0] op, input logic [15:0] addr,
                                   input logic [5:0] bank, input logic [7:0] dIn, input int hold,
                                   input int lat, input int mLow, input int iLow, input int falls,
                                   input int cLow, input logic [15:0] expA, input logic [7:0] data,
                                   input logic err, input logic [5:0] sBank, input logic sLock);
        vecT v;
        v.op = op; v.addr = addr; v.bank = bank; v.dIn = dIn; v.hold = hold;
        v.expLatency = lat; v.expMreqLow = mLow; v.expIorqLow = iLow;
        v.expIorqFalls = falls; v.expCartLow = cLow; v.expA = expA;
        v.expData = data; v.expErr = err; v.expBank = sBank; v.expLock = sLock;
        vecs.push_back(v);
    endfunction

    // Issue one command, keep cmd_valid up for v.hold cycles (switching the
    // op to PAGE_UP while busy so a wrongly accepted request would show),
    // and tally bus activity until rsp_valid or a cycle budget runs out.
    task automatic applyStimulus(input vecT v, output measT m);
        logic prevIorq;
        int   k;
        m = '{default: 0};
        m.latency = -1;
        @(negedge clk);
        busIf.cmd_op    = v.op;
        busIf.cmd_addr  = v.addr;
        busIf.cmd_bank  = v.bank;
        busIf.d_in      = v.dIn;
        busIf.cmd_valid = 1'b1;
        @(posedge clk);
        prevIorq = 1'b1;
        k = 0;
        while (k < 200) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                m.readyDuring = busIf.cmd_ready;
                busIf.cmd_op  = OP_PAGE;
            end
            if (k >= v.hold) busIf.cmd_valid = 1'b0;
            if (!busIf.mreq_n) m.mreqLow++;
            if (!busIf.iorq_n) m.iorqLow++;
            if (!busIf.rd_n) m.rdLow++;
            if (!busIf.iorq_n && prevIorq) m.iorqFalls++;
            prevIorq = busIf.iorq_n;
            if (!busIf.cart_reset_n) m.cartLow++;
            if ((!busIf.mreq_n || !busIf.iorq_n) && (busIf.A !== v.expA)) m.aBad++;
            if (busIf.rsp_valid === 1'b1) begin
                m.latency = k;
                m.data    = busIf.rsp_data;
                m.err     = busIf.rsp_err;
                break;
            end
        end
        busIf.cmd_valid = 1'b0;
        m.bank = busIf.shadow_bank;
        m.lock = busIf.shadow_lock;
        @(negedge clk);
        m.readyAfter = busIf.cmd_ready;
        m.rspAfter   = busIf.rsp_valid;
    endtask

    initial begin
        measT m;
        vecT  v;
        logic rspSeen;

        busIf.cmd_valid = 1'b0;
        busIf.cmd_op    = OP_MEM;
        busIf.cmd_addr  = 16'h0000;
        busIf.cmd_bank  = 6'd0;
        busIf.d_in      = 8'h00;

        // op, addr, bank, dIn, hold, lat, mreqLow, iorqLow, falls, cartLow, A, data, err, bank, lock
        addVec(OP_MEM,  16'h0123, 6'd0,  8'hA5, 1, 7,  4, 0, 0, 0, 16'h0123, 8'hA5, 1'b0, 6'd0, 1'b0);
        addVec(OP_PAGE, 16'h0000, 6'd0,  8'h00, 1, 9,  0, 6, 1, 0, 16'h007F, 8'h01, 1'b0, 6'd1, 1'b0);
        addVec(OP_PAGE, 16'h0000, 6'd0,  8'h00, 1, 9,  0, 6, 1, 0, 16'h007F, 8'h02, 1'b0, 6'd2, 1'b0);
        addVec(OP_PAGE, 16'h0000, 6'd0,  8'h00, 1, 9,  0, 6, 1, 0, 16'h007F, 8'h03, 1'b0, 6'd3, 1'b0);
        addVec(OP_RST,  16'h0000, 6'd0,  8'h00, 1, 5,  0, 0, 0, 4, 16'h0000, 8'h00, 1'b0, 6'd0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            addVec(OP_PAGE, 16'h0000, 6'd0, 8'h00, 1, 9, 0, 6, 1, 0, 16'h007F,
                   8'(i + 1), 1'b0, 6'(i + 1), (i == 15));
        end
        addVec(OP_PAGE, 16'h0000, 6'd0,  8'h00, 1, 9,  0, 6,  1, 0, 16'h007F, 8'h10, 1'b1, 6'd16, 1'b1);
        addVec(OP_MEM,  16'h8000, 6'd0,  8'h3C, 1, 7,  4, 0,  0, 0, 16'h8000, 8'h3C, 1'b1, 6'd16, 1'b1);
        addVec(OP_SEL,  16'h0000, 6'd5,  8'h00, 1, 55, 0, 30, 5, 4, 16'h007F, 8'h05, 1'b0, 6'd5,  1'b0);
        addVec(OP_SEL,  16'h0000, 6'd16, 8'h00, 1, 1,  0, 0,  0, 0, 16'h007F, 8'h05, 1'b1, 6'd5,  1'b0);
        addVec(OP_MEM,  16'hFFFF, 6'd0,  8'h5A, 5, 7,  4, 0,  0, 0, 16'hFFFF, 8'h5A, 1'b0, 6'd5,  1'b0);
        addVec(OP_SEL,  16'h0000, 6'd0,  8'h00, 1, 5,  0, 0,  0, 4, 16'h007F, 8'h00, 1'b0, 6'd0,  1'b0);
        addVec(OP_PAGE, 16'h0000, 6'd0,  8'h00, 1, 9,  0, 6,  1, 0, 16'h007F, 8'h01, 1'b0, 6'd1,  1'b0);

        // Reset state while reset_n is held low.
        repeat (3) @(negedge clk);
        checkOutput("rst cart_reset_n", busIf.cart_reset_n, 0);
        checkOutput("rst mreq_n", busIf.mreq_n, 1);
        checkOutput("rst iorq_n", busIf.iorq_n, 1);
        checkOutput("rst rd_n", busIf.rd_n, 1);
        checkOutput("rst A", busIf.A, 16'h0000);
        checkOutput("rst shadow_bank", busIf.shadow_bank, 0);
        checkOutput("rst shadow_lock", busIf.shadow_lock, 0);
        checkOutput("rst rsp_valid", busIf.rsp_valid, 0);
        checkOutput("rst rsp_data", busIf.rsp_data, 0);
        checkOutput("rst rsp_err", busIf.rsp_err, 0);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("release cart_reset_n", busIf.cart_reset_n, 1);
        checkOutput("release cmd_ready", busIf.cmd_ready, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            applyStimulus(v, m);
            checkOutput($sformatf("v%0d latency", i), m.latency, v.expLatency);
            checkOutput($sformatf("v%0d rsp_data", i), m.data, v.expData);
            checkOutput($sformatf("v%0d rsp_err", i), m.err, v.expErr);
            checkOutput($sformatf("v%0d shadow_bank", i), m.bank, v.expBank);
            checkOutput($sformatf("v%0d shadow_lock", i), m.lock, v.expLock);
            checkOutput($sformatf("v%0d mreq_n low clks", i), m.mreqLow, v.expMreqLow);
            checkOutput($sformatf("v%0d iorq_n low clks", i), m.iorqLow, v.expIorqLow);
            checkOutput($sformatf("v%0d rd_n low clks", i), m.rdLow, v.expMreqLow + v.expIorqLow);
            checkOutput($sformatf("v%0d iorq_n pulses", i), m.iorqFalls, v.expIorqFalls);
            checkOutput($sformatf("v%0d cart_reset_n low clks", i), m.cartLow, v.expCartLow);
            checkOutput($sformatf("v%0d A during strobe", i), m.aBad, 0);
            checkOutput($sformatf("v%0d cmd_ready busy", i), m.readyDuring, 0);
            checkOutput($sformatf("v%0d cmd_ready after", i), m.readyAfter, 1);
            checkOutput($sformatf("v%0d rsp_valid single", i), m.rspAfter, 0);
        end

        // Reset asserted during T2 of a memory read aborts it without a response.
        @(negedge clk);
        busIf.cmd_op    = OP_MEM;
        busIf.cmd_addr  = 16'h4444;
        busIf.d_in      = 8'h99;
        busIf.cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        busIf.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("midrst mreq_n in T2", busIf.mreq_n, 0);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("midrst mreq_n", busIf.mreq_n, 1);
        checkOutput("midrst rd_n", busIf.rd_n, 1);
        checkOutput("midrst cart_reset_n", busIf.cart_reset_n, 0);
        checkOutput("midrst A", busIf.A, 16'h0000);
        checkOutput("midrst shadow_bank", busIf.shadow_bank, 0);
        rspSeen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (busIf.rsp_valid !== 1'b0) rspSeen = 1'b1;
        end
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("midrst cmd_ready after", busIf.cmd_ready, 1);
        checkOutput("midrst cart_reset_n after", busIf.cart_reset_n, 1);
        repeat (10) begin
            @(negedge clk);
            if (busIf.rsp_valid !== 1'b0) rspSeen = 1'b1;
        end
        checkOutput("midrst no rsp_valid", rspSeen, 0);
        checkOutput("bus invariants", invViol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
